// File: rtl/led_activity.sv
// rtl/led_activity.sv - LED pulse stretcher: per-channel on-pulse, off-gap and one pending event
module led_activity #(
    parameter int LED_WIDTH     = 4,
    parameter int CLK_CNT_WIDTH = 24,
    parameter int HOLD_TICKS    = 3,
    parameter int GAP_TICKS     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CLK_CNT_WIDTH-1:0] div,
    input  logic [LED_WIDTH-1:0]     evt,
    output logic [LED_WIDTH-1:0]     led_out,
    output logic                     tick_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);
    localparam logic [7:0] GAP_INIT  = 8'(GAP_TICKS);

    localparam logic [CLK_CNT_WIDTH:0] ONE_EXT = {{CLK_CNT_WIDTH{1'b0}}, 1'b1};

    logic [CLK_CNT_WIDTH-1:0] cnt;
    logic [CLK_CNT_WIDTH:0]   cnt_inc;
    logic [CLK_CNT_WIDTH:0]   period;
    logic                     tick_hit;

    // One extra bit on the compare so cnt+1 never wraps; a lowered div fires on the next edge.
    assign cnt_inc  = {1'b0, cnt} + ONE_EXT;
    assign period   = (div == '0) ? ONE_EXT : {1'b0, div};
    assign tick_hit = (cnt_inc >= period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            tick_out <= 1'b0;
        end else if (tick_hit) begin
            cnt      <= '0;
            tick_out <= 1'b1;
        end else begin
            cnt      <= cnt_inc[CLK_CNT_WIDTH-1:0];
            tick_out <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LED_WIDTH; gi++) begin : g_ch
            logic [1:0] state;
            logic [1:0] state_nxt;
            logic [7:0] hc;
            logic [7:0] hc_nxt;
            logic       pend;
            logic       pend_nxt;
            logic       led_q;
            logic       expire;

            // The FSM sees the registered tick, i.e. the value present before this edge.
            assign expire = tick_out && (hc == 8'd1);

            always_comb begin
                state_nxt = state;
                hc_nxt    = hc;
                pend_nxt  = pend;
                case (state)
                    ST_IDLE: begin
                        if (evt[gi]) begin
                            state_nxt = ST_ON;
                            hc_nxt    = HOLD_INIT;
                            pend_nxt  = 1'b0;
                        end
                    end
                    ST_ON: begin
                        if (evt[gi]) begin
                            pend_nxt = 1'b1;
                        end
                        if (expire) begin
                            state_nxt = ST_GAP;
                            hc_nxt    = GAP_INIT;
                        end else if (tick_out) begin
                            hc_nxt = hc - 8'd1;
                        end
                    end
                    ST_GAP: begin
                        if (evt[gi]) begin
                            pend_nxt = 1'b1;
                        end
                        if (expire) begin
                            if (pend || evt[gi]) begin
                                state_nxt = ST_ON;
                                hc_nxt    = HOLD_INIT;
                                pend_nxt  = 1'b0;
                            end else begin
                                state_nxt = ST_IDLE;
                                hc_nxt    = 8'd0;
                            end
                        end else if (tick_out) begin
                            hc_nxt = hc - 8'd1;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        hc_nxt    = 8'd0;
                        pend_nxt  = 1'b0;
                    end
                endcase
            end

            // LED is its own flop loaded from the next state, so the pin never sees decode glitches.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= ST_IDLE;
                    hc    <= 8'd0;
                    pend  <= 1'b0;
                    led_q <= 1'b0;
                end else begin
                    state <= state_nxt;
                    hc    <= hc_nxt;
                    pend  <= pend_nxt;
                    led_q <= (state_nxt == ST_ON);
                end
            end

            assign led_out[gi] = led_q;
        end
    endgenerate

endmodule

// File: tb/tb_led_activity.sv
// tb/tb_led_activity.sv - scoreboard bench for led_activity (2 channels, hold 3, gap 2)
module tb_led_activity;

    localparam int LW   = 2;
    localparam int CW   = 24;
    localparam int HOLD = 3;
    localparam int GAP  = 2;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] div;
    logic [LW-1:0] evt;
    logic [LW-1:0] led_out;
    logic          tick_out;

    typedef struct {
        int        n;
        logic [1:0] led;
        logic      tick;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    led_activity #(
        .LED_WIDTH    (LW),
        .CLK_CNT_WIDTH(CW),
        .HOLD_TICKS   (HOLD),
        .GAP_TICKS    (GAP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div     (div),
        .evt     (evt),
        .led_out (led_out),
        .tick_out(tick_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge n (1-based after release) leaves tick_out high when n is a multiple of the period.
    function automatic logic exp_tick(int n, int p);
        return (n >= 1) && (n % p == 0);
    endfunction

    // Edge at which the k-th tick sampled after entry edge s is consumed.
    function automatic int nth_tick(int s, int k, int p);
        int e = s;
        int c = 0;
        while (c < k) begin
            e++;
            if (e > p && (e - 1) % p == 0) c++;
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        evt   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t x, e;
        evt = 2'b11;
        div = 24'd1;
        repeat (3) @(negedge clk);
        x.n = 0; x.led = 2'b00; x.tick = 1'b0;
        sb.push_back(x);
        e = sb.pop_front();
        n_checks++;
        if (led_out !== e.led) $display("FAIL reset led_out=%b expected %b", led_out, e.led);
        else n_pass++;
        n_checks++;
        if (tick_out !== e.tick) $display("FAIL reset tick_out=%b expected %b", tick_out, e.tick);
        else n_pass++;
        evt = '0;
    endtask

    task automatic test_tick();
        exp_t x, e;
        div = 24'd4;
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            if (n == 13) div = 24'd0;
            x.n = n; x.led = 2'b00; x.tick = (n <= 12) ? exp_tick(n, 4) : 1'b1;
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (tick_out !== e.tick) $display("FAIL tick edge %0d tick_out=%b expected %b", e.n, tick_out, e.tick);
            else n_pass++;
        end
        div = 24'd4;
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            if (n == 3) div = 24'd2;
            x.n = n; x.led = 2'b00; x.tick = (n >= 3) && (n % 2 == 1);
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (tick_out !== e.tick) $display("FAIL tick_lowered edge %0d tick_out=%b expected %b", e.n, tick_out, e.tick);
            else n_pass++;
        end
        div = 24'd4;
    endtask

    task automatic test_single();
        exp_t x, e;
        int a1, b1, g1, a2, b2;
        div = 24'd4;
        do_reset();
        a1 = 5;
        b1 = nth_tick(a1, HOLD, 4);
        g1 = nth_tick(b1, GAP, 4);
        a2 = g1 + 1;
        b2 = nth_tick(a2, HOLD, 4);
        for (int n = 1; n <= 40; n++) begin
            evt = (n == a1 || n == a2) ? 2'b01 : 2'b00;
            x.n = n;
            x.led = {1'b0, ((n >= a1 && n < b1) || (n >= a2 && n < b2))};
            x.tick = exp_tick(n, 4);
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (led_out !== e.led) $display("FAIL single edge %0d led_out=%b expected %b", e.n, led_out, e.led);
            else n_pass++;
            n_checks++;
            if (tick_out !== e.tick) $display("FAIL single_tick edge %0d tick_out=%b expected %b", e.n, tick_out, e.tick);
            else n_pass++;
        end
        evt = '0;
    endtask

    task automatic test_pending();
        exp_t x, e;
        int b1, a2, b2, rises;
        logic prev;
        div = 24'd4;
        do_reset();
        b1 = nth_tick(5, HOLD, 4);
        a2 = nth_tick(b1, GAP, 4);
        b2 = nth_tick(a2, HOLD, 4);
        rises = 0;
        prev = 1'b0;
        for (int n = 1; n <= 56; n++) begin
            evt = (n == 5 || n == 7 || n == 10 || n == 20) ? 2'b01 : 2'b00;
            x.n = n;
            x.led = {1'b0, ((n >= 5 && n < b1) || (n >= a2 && n < b2))};
            x.tick = exp_tick(n, 4);
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            if (led_out[0] && !prev) rises++;
            prev = led_out[0];
            n_checks++;
            if (led_out !== e.led) $display("FAIL pending edge %0d led_out=%b expected %b", e.n, led_out, e.led);
            else n_pass++;
        end
        evt = '0;
        n_checks++;
        if (rises !== 2) $display("FAIL pending_count pulses=%0d expected 2", rises);
        else n_pass++;
    endtask

    task automatic test_boundary();
        exp_t x, e;
        int b1, g1, b2;
        b1 = nth_tick(5, HOLD, 4);
        g1 = nth_tick(b1, GAP, 4);
        b2 = nth_tick(g1, HOLD, 4);
        for (int sc = 0; sc < 2; sc++) begin
            div = 24'd4;
            do_reset();
            for (int n = 1; n <= 44; n++) begin
                // scenario 0: event on the gap-expiry edge; scenario 1: event on the on-expiry edge
                evt = (n == 5 || n == ((sc == 0) ? g1 : b1)) ? 2'b01 : 2'b00;
                x.n = n;
                x.led = {1'b0, ((n >= 5 && n < b1) || (n >= g1 && n < b2))};
                x.tick = exp_tick(n, 4);
                sb.push_back(x);
                @(negedge clk);
                e = sb.pop_front();
                n_checks++;
                if (led_out !== e.led) $display("FAIL boundary%0d edge %0d led_out=%b expected %b", sc, e.n, led_out, e.led);
                else n_pass++;
            end
            evt = '0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t x, e;
        int b1;
        div = 24'd4;
        do_reset();
        b1 = nth_tick(5, HOLD, 4);
        for (int n = 1; n <= 12; n++) begin
            evt = (n == 5 || n == 8) ? 2'b01 : 2'b00;
            x.n = n; x.led = {1'b0, (n >= 5 && n < b1)}; x.tick = exp_tick(n, 4);
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (led_out !== e.led) $display("FAIL reset_mid_pre edge %0d led_out=%b expected %b", e.n, led_out, e.led);
            else n_pass++;
        end
        evt = '0;
        #2 rst_n = 1'b0;
        #1;
        x.n = 0; x.led = 2'b00; x.tick = 1'b0;
        sb.push_back(x);
        e = sb.pop_front();
        n_checks++;
        if (led_out !== e.led) $display("FAIL reset_mid_async led_out=%b expected %b", led_out, e.led);
        else n_pass++;
        n_checks++;
        if (tick_out !== e.tick) $display("FAIL reset_mid_async tick_out=%b expected %b", tick_out, e.tick);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            x.n = n; x.led = 2'b00; x.tick = exp_tick(n, 4);
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (led_out !== e.led) $display("FAIL reset_mid_post edge %0d led_out=%b expected %b", e.n, led_out, e.led);
            else n_pass++;
            n_checks++;
            if (tick_out !== e.tick) $display("FAIL reset_mid_tick edge %0d tick_out=%b expected %b", e.n, tick_out, e.tick);
            else n_pass++;
        end
    endtask

    task automatic test_parallel();
        exp_t x, e;
        int b1, g1, b2;
        logic on0, on1;
        div = 24'd4;
        do_reset();
        b1 = nth_tick(6, HOLD, 4);
        g1 = nth_tick(b1, GAP, 4);
        b2 = nth_tick(g1, HOLD, 4);
        for (int n = 1; n <= 44; n++) begin
            evt = (n == 6) ? 2'b11 : ((n == 20) ? 2'b10 : 2'b00);
            on0 = (n >= 6 && n < b1);
            on1 = (n >= 6 && n < b1) || (n >= g1 && n < b2);
            x.n = n; x.led = {on1, on0}; x.tick = exp_tick(n, 4);
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (led_out !== e.led) $display("FAIL parallel edge %0d led_out=%b expected %b", e.n, led_out, e.led);
            else n_pass++;
        end
        evt = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        div   = 24'd4;
        evt   = '0;
        test_reset();
        test_tick();
        test_single();
        test_pending();
        test_boundary();
        test_reset_mid();
        test_parallel();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
